// File: rtl/bp_pkg.sv
// Shared branch-predictor constants: default geometry, index-mode encodings
// and the weakly-not-taken counter reset value.
package bp_pkg;

    localparam int unsigned HIST_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 2;
    localparam int unsigned PC_W_DEF   = 32;

    localparam int unsigned MODE_GLOBAL = 0;
    localparam int unsigned MODE_GSHARE = 1;

    localparam logic [CNT_W_DEF-1:0] WEAK_NT = 2'b01;

    // Largest value whose MSB is still clear, for any counter width.
    function automatic int unsigned weak_nt(input int unsigned cnt_w);
        return (32'd1 << (cnt_w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up/down saturating counter for one pattern-history table entry.
module sat_counter #(
    parameter int unsigned          CNT_W   = 2,
    parameter logic [CNT_W-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (en) begin
            if (inc && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end else if (!inc && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Global-history branch direction predictor (history-only or gshare index)
// with speculative/architectural history and a misprediction counter.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned HIST_W = HIST_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned MODE   = MODE_GSHARE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Pred_Valid,
    input  logic [PC_W-1:0]   Pred_PC,
    output logic              Pred_Taken,
    output logic [HIST_W-1:0] Pred_Index,
    input  logic              Upd_Valid,
    input  logic [HIST_W-1:0] Upd_Index,
    input  logic              Upd_Taken,
    input  logic              Upd_Mispredict,
    output logic [15:0]       Mispred_Count
);

    localparam int unsigned      DEPTH   = 2 ** HIST_W;
    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(weak_nt(CNT_W));

    logic [HIST_W-1:0] spec_hist;
    logic [HIST_W-1:0] arch_hist;
    logic [CNT_W-1:0]  cnt [DEPTH];
    logic              flush;
    logic              unused_pc;

    // Only PC[HIST_W+1:2] feeds the index; the rest is intentionally ignored.
    assign unused_pc = ^Pred_PC;

    if (MODE == MODE_GSHARE) begin : g_gshare
        assign Pred_Index = Pred_PC[HIST_W+1:2] ^ spec_hist;
    end else begin : g_global
        assign Pred_Index = spec_hist;
    end

    // Reads the registered counter, so a same-cycle update is not bypassed.
    assign Pred_Taken = cnt[Pred_Index][CNT_W-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_pht
        sat_counter #(
            .CNT_W   (CNT_W),
            .RST_VAL (RST_CNT)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (Upd_Valid && (Upd_Index == HIST_W'(i))),
            .inc   (Upd_Taken),
            .cnt   (cnt[i])
        );
    end

    assign flush = Upd_Valid && Upd_Mispredict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_hist <= '0;
            arch_hist <= '0;
        end else begin
            if (Upd_Valid) begin
                arch_hist <= {arch_hist[HIST_W-2:0], Upd_Taken};
            end
            // A flush repairs history from the resolved path and squashes fetch.
            if (flush) begin
                spec_hist <= {arch_hist[HIST_W-2:0], Upd_Taken};
            end else if (Pred_Valid) begin
                spec_hist <= {spec_hist[HIST_W-2:0], Pred_Taken};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Mispred_Count <= '0;
        end else if (flush && (Mispred_Count != 16'hFFFF)) begin
            Mispred_Count <= Mispred_Count + 16'd1;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Randomized and directed bench for gshare_predictor, one instance per index
// mode, checked against an array-based reference model.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic        upd_taken;
    logic        upd_mis;
    logic [7:0]  upd_idx0;
    logic [7:0]  upd_idx1;
    logic        taken0;
    logic        taken1;
    logic [7:0]  index0;
    logic [7:0]  index1;
    logic [15:0] mc0;
    logic [15:0] mc1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, [0] = history-only, [1] = gshare.
    int mcnt [2][256];
    int mspec [2];
    int march [2];
    int mmc [2];

    always #5 clk = ~clk;

    gshare_predictor #(.MODE(0)) dut0 (
        .clk            (clk),
        .rst_n          (rst_n),
        .Pred_Valid     (pred_valid),
        .Pred_PC        (pred_pc),
        .Pred_Taken     (taken0),
        .Pred_Index     (index0),
        .Upd_Valid      (upd_valid),
        .Upd_Index      (upd_idx0),
        .Upd_Taken      (upd_taken),
        .Upd_Mispredict (upd_mis),
        .Mispred_Count  (mc0)
    );

    gshare_predictor #(.MODE(1)) dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .Pred_Valid     (pred_valid),
        .Pred_PC        (pred_pc),
        .Pred_Taken     (taken1),
        .Pred_Index     (index1),
        .Upd_Valid      (upd_valid),
        .Upd_Index      (upd_idx1),
        .Upd_Taken      (upd_taken),
        .Upd_Mispredict (upd_mis),
        .Mispred_Count  (mc1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_idx(input int m);
        if (m == 1) return ((int'(pred_pc) >> 2) & 255) ^ mspec[1];
        return mspec[0];
    endfunction

    function automatic int model_taken(input int m);
        return (mcnt[m][model_idx(m)] >= 2) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 256; i++) mcnt[m][i] = 1;
            mspec[m] = 0;
            march[m] = 0;
            mmc[m]   = 0;
        end
    endtask

    // Applies one clock edge worth of behaviour, using pre-edge predictions.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            int tk   = model_taken(m);
            int ui   = (m == 1) ? int'(upd_idx1) : int'(upd_idx0);
            int arch = march[m];
            if (upd_valid) begin
                if (upd_taken && mcnt[m][ui] < 3) mcnt[m][ui]++;
                if (!upd_taken && mcnt[m][ui] > 0) mcnt[m][ui]--;
                march[m] = ((arch << 1) | int'(upd_taken)) & 255;
            end
            if (upd_valid && upd_mis) begin
                mspec[m] = ((arch << 1) | int'(upd_taken)) & 255;
                if (mmc[m] < 65535) mmc[m]++;
            end else if (pred_valid) begin
                mspec[m] = ((mspec[m] << 1) | tk) & 255;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("taken_m0", 32'(taken0), 32'(model_taken(0)));
        check_eq("index_m0", 32'(index0), 32'(model_idx(0)));
        check_eq("count_m0", 32'(mc0), 32'(mmc[0]));
        check_eq("taken_m1", 32'(taken1), 32'(model_taken(1)));
        check_eq("index_m1", 32'(index1), 32'(model_idx(1)));
        check_eq("count_m1", 32'(mc1), 32'(mmc[1]));
    endtask

    // Inputs are set at a negedge before calling; returns at the next negedge.
    task automatic cycle(input bit do_chk);
        #1;
        if (do_chk) check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        upd_taken  = 1'b0;
        upd_mis    = 1'b0;
        upd_idx0   = 8'h00;
        upd_idx1   = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        check_eq("rst_count", 32'(mc1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int exp_taken_32 [6] = '{1, 1, 1, 0, 0, 0};
    int outc_32 [6]      = '{1, 1, 0, 0, 0, 0};

    initial begin
        int mc_snap;
        rst_n   = 1'b0;
        pred_pc = 32'h0;
        idle_inputs();
        model_reset();

        // Reset state, gshare index of PC 0x40.
        do_reset();
        pred_pc = 32'h0000_0040;
        #1;
        check_eq("rst_taken", 32'(taken1), 32'd0);
        check_eq("rst_index", 32'(index1), 32'h10);
        check_eq("rst_mc", 32'(mc1), 32'd0);
        cycle(1);

        // Counter saturation at index 0, history-only mode.
        pred_pc = 32'h0;
        for (int k = 0; k < 6; k++) begin
            upd_valid = 1'b1;
            upd_taken = outc_32[k][0];
            cycle(1);
            #1;
            check_eq("sat_taken", 32'(taken0), 32'(exp_taken_32[k]));
        end
        idle_inputs();
        cycle(1);

        // Alternating pattern trains to perfect prediction.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            int outcome = k % 2;
            pred_valid = 1'b1;
            upd_valid  = 1'b1;
            upd_idx0   = 8'(model_idx(0));
            upd_idx1   = 8'(model_idx(1));
            upd_taken  = outcome[0];
            upd_mis    = (model_taken(0) != outcome);
            if (k == 12) mc_snap = mmc[0];
            if (k >= 12) begin
                #1;
                check_eq("alt_pred", 32'(taken0), 32'(outcome));
                check_eq("alt_mc", 32'(mc0), 32'(mc_snap));
            end
            cycle(1);
        end

        // Mispredict repair from arch_hist with a squashed fetch.
        do_reset();
        upd_valid = 1'b1;
        upd_idx0  = 8'h80;
        upd_idx1  = 8'h80;
        for (int k = 0; k < 3; k++) begin
            upd_taken = (k != 1);
            cycle(1);
        end
        idle_inputs();
        pred_valid = 1'b1;
        for (int k = 0; k < 3; k++) cycle(1);
        #1;
        check_eq("rep_spec0", 32'(index0), 32'h00);
        upd_valid = 1'b1;
        upd_mis   = 1'b1;
        upd_taken = 1'b1;
        cycle(1);
        idle_inputs();
        #1;
        check_eq("rep_spec", 32'(index0), 32'h0B);
        check_eq("rep_mc", 32'(mc0), 32'd1);
        cycle(1);

        // Same-cycle predict and update to 0x3C, no bypass.
        do_reset();
        pred_pc   = 32'h0000_00F0;
        upd_valid = 1'b1;
        upd_taken = 1'b1;
        upd_idx1  = 8'h3C;
        #1;
        check_eq("byp_index", 32'(index1), 32'h3C);
        check_eq("byp_now", 32'(taken1), 32'd0);
        cycle(1);
        idle_inputs();
        #1;
        check_eq("byp_next", 32'(taken1), 32'd1);
        cycle(1);

        // Random traffic.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            pred_valid = 1'($urandom);
            pred_pc    = $urandom;
            upd_valid  = 1'($urandom);
            upd_taken  = 1'($urandom);
            upd_mis    = ($urandom_range(0, 3) == 0);
            upd_idx0   = 8'($urandom);
            upd_idx1   = 8'($urandom);
            cycle(1);
        end

        // Counter saturation at 0xFFFF, then asynchronous reset.
        idle_inputs();
        upd_valid = 1'b1;
        upd_mis   = 1'b1;
        upd_taken = 1'b1;
        for (int k = 0; k < 65540; k++) begin
            pred_valid = 1'($urandom);
            pred_pc    = $urandom;
            upd_idx0   = 8'($urandom);
            upd_idx1   = 8'($urandom);
            cycle(0);
        end
        check_eq("mc_sat", 32'(mc1), 32'h0000_FFFF);
        cycle(1);
        check_eq("mc_hold", 32'(mc0), 32'h0000_FFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_mc1", 32'(mc1), 32'd0);
        check_eq("arst_mc0", 32'(mc0), 32'd0);
        idle_inputs();
        model_reset();
        for (int p = 0; p < 256; p++) begin
            pred_pc = 32'(p) << 2;
            #1;
            check_eq("arst_taken", 32'(taken1), 32'd0);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        pred_pc   = 32'h0000_00F0;
        upd_valid = 1'b1;
        upd_taken = 1'b1;
        upd_idx1  = 8'h3C;
        cycle(1);
        idle_inputs();
        #1;
        check_eq("first_upd", 32'(taken1), 32'd1);
        cycle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
